csr_access_arbiter: RTL and testbench
=====================================

CSR_ACCESS_ARBITER -- requirements
Module: csr_access_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter ALEN, default 12, CSR address width.
REQ-003 SHALL use clock clk; reset rst_n, synchronous, active-low.
REQ-004 SHALL have ports:
  clk  in  1  clock
  rst_n  in  1  sync active-low reset
  core_req  in  1  core CSR op request
  core_ready  out  1  core request accepted this cycle
  core_addr  in  ALEN  CSR address
  core_f3  in  3  funct3 of CSR instruction
  core_reg  in  XLEN  rs1 value
  core_imm  in  XLEN  zero-extended uimm
  core_rs  in  5  rs1 index
  core_rsp_valid  out  1  core response pulse
  dbg_req  in  1  debug abstract-command request
  dbg_ready  out  1  debug request accepted this cycle
  dbg_addr  in  ALEN  CSR address
  dbg_we  in  1  1 = write, 0 = read
  dbg_wdata  in  XLEN  write data
  dbg_rsp_valid  out  1  debug response pulse
  rsp_rdata  out  XLEN  old CSR value, shared by both responses
  rsp_invalid  out  1  access faulted, shared
  csr_addr, csr_f3, csr_reg, csr_imm, csr_rs  out  ALEN/3/XLEN/XLEN/5  operands to CSR file
  csr_write  out  1  commit strobe to CSR file
  csr_debug  out  1  access is debug-privileged
  csr_rdata  in  XLEN  CSR file combinational read
  csr_invalid  in  1  CSR file fault flag

Function
REQ-005 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-006 core_ready and dbg_ready SHALL be asserted only in IDLE, at most one per cycle, on the granted requester.
REQ-007 A single requester SHALL be granted in IDLE when its req is high.
REQ-008 When both req are high, the grant SHALL go to the requester not granted last; after reset, debug wins first.
REQ-009 A grant SHALL latch operands into registers and move to ACCESS.
REQ-010 Debug write latching SHALL be f3=CSRRW (001), reg=dbg_wdata, imm=0, rs=1.
REQ-011 Debug read latching SHALL be f3=CSRRS (010), reg=0, imm=0, rs=0, so the CSR file commits no write.
REQ-012 In ACCESS, the block SHALL drive the latched operands and csr_write=1 for exactly one cycle, with csr_debug=1 iff debug was granted.
REQ-013 In ACCESS, rsp_rdata and rsp_invalid SHALL be captured from csr_rdata and csr_invalid.
REQ-014 In RESP, the owner's rsp_valid SHALL pulse for one cycle, and the FSM SHALL return to IDLE.
REQ-015 Latency SHALL be: accept at cycle N, commit at N+1, response at N+2; throughput SHALL be 1 access per 3 cycles.
REQ-016 Outside ACCESS, csr_write SHALL be 0 and csr_* operands SHALL hold their last values.
REQ-017 Requests SHALL NOT be preempted, and req deasserted after accept SHALL NOT cancel the access.
REQ-018 rsp_rdata and rsp_invalid SHALL hold until the next RESP.

Reset
REQ-019 On reset, state SHALL be IDLE, last-grant SHALL be core, and all outputs SHALL be 0 (ready outputs go 1 in the first IDLE cycle if a req is present).
REQ-020 Reset during ACCESS or RESP SHALL abort the access with no csr_write and no rsp_valid.

Configuration
REQ-021 With CSR_ARB_DEBUG_EN defined, the debug port SHALL behave as above.
REQ-022 With CSR_ARB_DEBUG_EN undefined, dbg_ready and dbg_rsp_valid SHALL be tied to 0, csr_debug SHALL be tied to 0, dbg_* inputs SHALL be ignored, and the last-grant bit SHALL be removed.

Structure
REQ-023 The shared package csr_pkg SHALL hold the FSM state enum and F3 constants CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI.
REQ-024 Sub-module csr_arb_pick SHALL implement the 2-way last-grant-fair pick, with combinational output.

Verification
REQ-025 Core CSRRS addr 0x300, rs=0 -> csr_write at N+1 with f3=010, core_rsp_valid at N+2, rsp_rdata = mstatus value.
REQ-026 Debug write 0x341 data 0x80000004 -> csr_f3=001, csr_debug=1; a subsequent read returns 0x80000004.
REQ-027 Both req held high for 12 cycles -> grants alternate dbg, core, dbg, core; 4 responses total, none lost.
REQ-028 Core access to debug-only 0x7B0 -> rsp_invalid=1 and CSR unchanged; the same access from debug -> rsp_invalid=0.
REQ-029 rst_n low in the ACCESS cycle -> no csr_write, no rsp_valid; next cycle IDLE with ready honoured.
REQ-030 CSR_ARB_DEBUG_EN undefined, dbg_req=1 constantly -> dbg_ready never 1; core accesses complete at 3-cycle cadence.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: shared FSM state type and CSR instruction funct3 encodings.
// Used by csr_access_arbiter; holds no logic of its own.
package csr_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;

endpackage

// File: rtl/csr_arb_pick.sv
// csr_arb_pick: combinational 2-way pick between core and debug, fair by last grant.
// Ports: core_req, dbg_req  - pending requests
//        last_dbg           - 1 when debug held the previous grant
//        grant_core, grant_dbg - one-hot (or zero) grant
module csr_arb_pick (
    input  logic core_req,
    input  logic dbg_req,
    input  logic last_dbg,
    output logic grant_core,
    output logic grant_dbg
);

    // On a tie the requester that did not win last time gets the grant.
    assign grant_dbg  = dbg_req && (!core_req || !last_dbg);
    assign grant_core = core_req && !grant_dbg;

endmodule

// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter: serialises core CSR instructions and debug abstract commands
// onto one CSR file port (accept N, commit N+1, respond N+2).
// Ports: clk, rst_n (sync, active-low)
//        core_*  - core request/operands, core_ready accept strobe, core_rsp_valid pulse
//        dbg_*   - debug request/operands, dbg_ready accept strobe, dbg_rsp_valid pulse
//        rsp_rdata, rsp_invalid - old CSR value and fault flag, shared by both responses
//        csr_*   - latched operands and commit strobe to the CSR file, plus its read/fault
// Build option: CSR_ARB_DEBUG_EN enables the debug port; without it the debug
// inputs are ignored and debug outputs are tied low.
module csr_access_arbiter
    import csr_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ALEN = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            core_req,
    output logic            core_ready,
    input  logic [ALEN-1:0] core_addr,
    input  logic [2:0]      core_f3,
    input  logic [XLEN-1:0] core_reg,
    input  logic [XLEN-1:0] core_imm,
    input  logic [4:0]      core_rs,
    output logic            core_rsp_valid,
    input  logic            dbg_req,
    output logic            dbg_ready,
    input  logic [ALEN-1:0] dbg_addr,
    input  logic            dbg_we,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic            dbg_rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_invalid,
    output logic [ALEN-1:0] csr_addr,
    output logic [2:0]      csr_f3,
    output logic [XLEN-1:0] csr_reg,
    output logic [XLEN-1:0] csr_imm,
    output logic [4:0]      csr_rs,
    output logic            csr_write,
    output logic            csr_debug,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            csr_invalid
);

    state_t state, state_nx;
    logic   grant_core;
    logic   any_grant;

`ifdef CSR_ARB_DEBUG_EN
    logic grant_dbg;
    // Also marks the owner of the in-flight access: it is updated on every grant.
    logic last_dbg;

    csr_arb_pick u_pick (
        .core_req  (core_req),
        .dbg_req   (dbg_req),
        .last_dbg  (last_dbg),
        .grant_core(grant_core),
        .grant_dbg (grant_dbg)
    );

    assign any_grant = grant_core | grant_dbg;
    assign csr_debug = last_dbg;

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_dbg <= 1'b0;
        else if (core_ready || dbg_ready)
            last_dbg <= dbg_ready;
    end
`else
    logic unused_grant_dbg;
    logic unused_dbg;

    csr_arb_pick u_pick (
        .core_req  (core_req),
        .dbg_req   (1'b0),
        .last_dbg  (1'b0),
        .grant_core(grant_core),
        .grant_dbg (unused_grant_dbg)
    );

    assign unused_dbg = ^{dbg_req, dbg_addr, dbg_we, dbg_wdata, unused_grant_dbg};
    assign any_grant  = grant_core;
    assign csr_debug  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        state <= rst_n ? state_nx : S_IDLE;
    end

    // Strobes are qualified with rst_n so a reset cycle in ACCESS or RESP
    // produces neither a commit nor a response.
    always_comb begin
        state_nx   = (state == S_IDLE)   ? (any_grant ? S_ACCESS : S_IDLE) :
                     (state == S_ACCESS) ? S_RESP : S_IDLE;
        core_ready = rst_n && state == S_IDLE && grant_core;
        csr_write  = rst_n && state == S_ACCESS;
`ifdef CSR_ARB_DEBUG_EN
        dbg_ready      = rst_n && state == S_IDLE && grant_dbg;
        core_rsp_valid = rst_n && state == S_RESP && !last_dbg;
        dbg_rsp_valid  = rst_n && state == S_RESP && last_dbg;
`else
        dbg_ready      = 1'b0;
        core_rsp_valid = rst_n && state == S_RESP;
        dbg_rsp_valid  = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csr_addr    <= '0;
            csr_f3      <= '0;
            csr_reg     <= '0;
            csr_imm     <= '0;
            csr_rs      <= '0;
            rsp_rdata   <= '0;
            rsp_invalid <= 1'b0;
        end else begin
            if (core_ready) begin
                csr_addr <= core_addr;
                csr_f3   <= core_f3;
                csr_reg  <= core_reg;
                csr_imm  <= core_imm;
                csr_rs   <= core_rs;
            end
`ifdef CSR_ARB_DEBUG_EN
            // A debug read is CSRRS with rs=0, which the CSR file treats as no write.
            else if (dbg_ready) begin
                csr_addr <= dbg_addr;
                csr_f3   <= dbg_we ? CSRRW : CSRRS;
                csr_reg  <= dbg_we ? dbg_wdata : '0;
                csr_imm  <= '0;
                csr_rs   <= {4'd0, dbg_we};
            end
`endif
            if (state == S_ACCESS) begin
                rsp_rdata   <= csr_rdata;
                rsp_invalid <= csr_invalid;
            end
        end
    end

endmodule

// File: tb/tb_csr_access_arbiter.sv
// tb_csr_access_arbiter: directed, table-driven check of csr_access_arbiter
// against a small behavioural CSR file (0x300, 0x341, debug-only 0x7B0).
module tb_csr_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_ready, core_rsp_valid;
    logic [11:0] core_addr;
    logic [2:0]  core_f3;
    logic [31:0] core_reg, core_imm;
    logic [4:0]  core_rs;
    logic        dbg_req, dbg_ready, dbg_we, dbg_rsp_valid;
    logic [11:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] rsp_rdata;
    logic        rsp_invalid;
    logic [11:0] csr_addr;
    logic [2:0]  csr_f3;
    logic [31:0] csr_reg, csr_imm;
    logic [4:0]  csr_rs;
    logic        csr_write, csr_debug;
    logic [31:0] csr_rdata;
    logic        csr_invalid;

    int n_cmp = 0;
    int n_err = 0;

`ifdef CSR_ARB_DEBUG_EN
    localparam bit DBG_IDLE = 1'b0;
`else
    localparam bit DBG_IDLE = 1'b1;
`endif

    always #5 clk = ~clk;

    csr_access_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_ready(core_ready), .core_addr(core_addr),
        .core_f3(core_f3), .core_reg(core_reg), .core_imm(core_imm), .core_rs(core_rs),
        .core_rsp_valid(core_rsp_valid),
        .dbg_req(dbg_req), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_we(dbg_we),
        .dbg_wdata(dbg_wdata), .dbg_rsp_valid(dbg_rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_invalid(rsp_invalid),
        .csr_addr(csr_addr), .csr_f3(csr_f3), .csr_reg(csr_reg), .csr_imm(csr_imm),
        .csr_rs(csr_rs), .csr_write(csr_write), .csr_debug(csr_debug),
        .csr_rdata(csr_rdata), .csr_invalid(csr_invalid)
    );

    // Behavioural CSR file
    logic [31:0] r300 = 32'h0000_1800;
    logic [31:0] r341 = 32'h0000_0000;
    logic [31:0] r7b0 = 32'h4000_0003;
    logic [31:0] src, nv;
    logic        wr;

    always_comb begin
        csr_rdata   = (csr_addr == 12'h300) ? r300 : (csr_addr == 12'h341) ? r341 :
                      (csr_addr == 12'h7B0) ? r7b0 : 32'h0;
        csr_invalid = (csr_addr == 12'h7B0) && !csr_debug;
        src         = csr_f3[2] ? csr_imm : csr_reg;
        wr          = (csr_f3[1:0] == 2'b01) || (csr_rs != 5'd0);
        nv          = (csr_f3[1:0] == 2'b01) ? src :
                      (csr_f3[1:0] == 2'b10) ? (csr_rdata | src) : (csr_rdata & ~src);
    end

    always @(posedge clk) begin
        if (csr_write && !csr_invalid && wr) begin
            if (csr_addr == 12'h300) r300 <= nv;
            if (csr_addr == 12'h341) r341 <= nv;
            if (csr_addr == 12'h7B0) r7b0 <= nv;
        end
    end

    typedef struct {
        bit          dbg;
        bit          we;
        logic [11:0] addr;
        logic [2:0]  f3;
        logic [31:0] rg;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [31:0] exp_rdata;
        bit          exp_inv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit dbg, bit we, logic [11:0] addr, logic [2:0] f3,
                                logic [31:0] rg, logic [31:0] imm, logic [4:0] rs,
                                logic [31:0] er, bit ei);
        vec_t v;
        v.dbg = dbg; v.we = we; v.addr = addr; v.f3 = f3; v.rg = rg; v.imm = imm;
        v.rs = rs; v.exp_rdata = er; v.exp_inv = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called in the low clock phase; returns in the low phase of the IDLE cycle after RESP.
    task automatic do_access(input vec_t v, output int waited);
        logic [2:0]  ef3;
        logic [31:0] ereg, eimm;
        logic [4:0]  ers;
        ef3  = v.dbg ? (v.we ? 3'b001 : 3'b010) : v.f3;
        ereg = v.dbg ? (v.we ? v.rg : 32'h0) : v.rg;
        eimm = v.dbg ? 32'h0 : v.imm;
        ers  = v.dbg ? {4'd0, v.we} : v.rs;
        core_req  = !v.dbg;
        core_addr = v.addr; core_f3 = v.f3; core_reg = v.rg; core_imm = v.imm; core_rs = v.rs;
        dbg_req   = v.dbg | DBG_IDLE;
        dbg_addr  = v.addr; dbg_we = v.we; dbg_wdata = v.rg;
        waited = 0;
        #1;
        while (!(v.dbg ? dbg_ready : core_ready) && waited < 10) begin
            @(negedge clk); #1;
            waited++;
        end
        if (waited >= 10) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: no ready within 10 cycles for addr %0h", v.addr);
            core_req = 1'b0; dbg_req = DBG_IDLE;
            return;
        end
        chk("accept_other_ready", v.dbg ? core_ready : dbg_ready, 0);
        chk("accept_no_rsp", {core_rsp_valid, dbg_rsp_valid}, 0);
        @(negedge clk);
        core_req = 1'b0; dbg_req = DBG_IDLE;
        #1;
        chk("access_write", csr_write, 1);
        chk("access_addr", csr_addr, v.addr);
        chk("access_f3", csr_f3, ef3);
        chk("access_reg", csr_reg, ereg);
        chk("access_imm", csr_imm, eimm);
        chk("access_rs", csr_rs, ers);
        chk("access_debug", csr_debug, v.dbg);
        chk("access_ready", {core_ready, dbg_ready}, 0);
        chk("access_no_rsp", {core_rsp_valid, dbg_rsp_valid}, 0);
        @(negedge clk); #1;
        chk("resp_valid", {core_rsp_valid, dbg_rsp_valid}, v.dbg ? 2'b01 : 2'b10);
        chk("resp_no_write", csr_write, 0);
        chk("resp_rdata", rsp_rdata, v.exp_rdata);
        chk("resp_invalid", rsp_invalid, v.exp_inv);
        chk("resp_f3_hold", csr_f3, ef3);
        @(negedge clk); #1;
        chk("post_no_rsp", {core_rsp_valid, dbg_rsp_valid}, 0);
        chk("post_rdata_hold", rsp_rdata, v.exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n_core_rsp, n_dbg_rsp;
        rst_n = 1'b0;
        core_req = 1'b0; core_addr = 12'h300; core_f3 = 3'b010; core_reg = 32'h0;
        core_imm = 32'h0; core_rs = 5'd0;
        dbg_req = 1'b1; dbg_addr = 12'h341; dbg_we = DBG_IDLE; dbg_wdata = 32'hA5A5_5A5A;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_core_ready", core_ready, 0);
        chk("rst_dbg_ready", dbg_ready, 0);
        chk("rst_write", csr_write, 0);
        chk("rst_rsp_valid", {core_rsp_valid, dbg_rsp_valid}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_invalid", rsp_invalid, 0);
        chk("rst_csr_addr", csr_addr, 0);
        chk("rst_csr_f3", csr_f3, 0);
        chk("rst_csr_debug", csr_debug, 0);

        // Both requests held for 12 cycles straight out of reset
        @(negedge clk);
        rst_n = 1'b1; core_req = 1'b1; dbg_req = 1'b1;
        n_core_rsp = 0; n_dbg_rsp = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_core_rsp += int'(core_rsp_valid);
            n_dbg_rsp  += int'(dbg_rsp_valid);
`ifdef CSR_ARB_DEBUG_EN
            chk($sformatf("alt_dbg_ready_%0d", i), dbg_ready, (i % 6) == 0);
            chk($sformatf("alt_core_ready_%0d", i), core_ready, (i % 6) == 3);
`else
            chk($sformatf("cad_core_ready_%0d", i), core_ready, (i % 3) == 0);
            chk($sformatf("cad_write_%0d", i), csr_write, (i % 3) == 1);
            chk($sformatf("cad_rsp_%0d", i), core_rsp_valid, (i % 3) == 2);
            chk($sformatf("cad_dbg_out_%0d", i), {dbg_ready, dbg_rsp_valid, csr_debug}, 0);
`endif
            @(negedge clk);
        end
`ifdef CSR_ARB_DEBUG_EN
        chk("alt_core_rsp_count", n_core_rsp, 2);
        chk("alt_dbg_rsp_count", n_dbg_rsp, 2);
`else
        chk("cad_core_rsp_count", n_core_rsp, 4);
        chk("cad_dbg_rsp_count", n_dbg_rsp, 0);
`endif
        core_req = 1'b0; dbg_req = DBG_IDLE;

        // Core table
        vecs.push_back(mk(0, 0, 12'h300, 3'b010, 32'h0,         32'h0, 5'd0, 32'h0000_1800, 0));
        vecs.push_back(mk(0, 0, 12'h341, 3'b001, 32'h8000_0004, 32'h0, 5'd1, 32'h0000_0000, 0));
        vecs.push_back(mk(0, 0, 12'h341, 3'b010, 32'h0,         32'h0, 5'd0, 32'h8000_0004, 0));
        vecs.push_back(mk(0, 0, 12'h300, 3'b110, 32'hFFFF_FFFF, 32'h5, 5'd5, 32'h0000_1800, 0));
        vecs.push_back(mk(0, 0, 12'h300, 3'b011, 32'h0000_0800, 32'h0, 5'd2, 32'h0000_1805, 0));
        vecs.push_back(mk(0, 0, 12'h300, 3'b010, 32'h0,         32'h0, 5'd0, 32'h0000_1005, 0));
        vecs.push_back(mk(0, 0, 12'h7B0, 3'b001, 32'h0,         32'h0, 5'd1, 32'h4000_0003, 1));
        vecs.push_back(mk(0, 0, 12'h7B0, 3'b010, 32'h0,         32'h0, 5'd0, 32'h4000_0003, 1));
        vecs.push_back(mk(0, 0, 12'h341, 3'b111, 32'h0,         32'h4, 5'd4, 32'h8000_0004, 0));
        vecs.push_back(mk(0, 0, 12'h341, 3'b010, 32'h0,         32'h0, 5'd0, 32'h8000_0000, 0));
        foreach (vecs[k]) do_access(vecs[k], w);

        // Reset asserted in the ACCESS cycle aborts the write
        core_req = 1'b1; core_addr = 12'h341; core_f3 = 3'b001;
        core_reg = 32'hDEAD_0000; core_imm = 32'h0; core_rs = 5'd1;
        #1;
        chk("abort_accept", core_ready, 1);
        @(negedge clk);
        core_req = 1'b0; rst_n = 1'b0;
        #1;
        chk("abort_no_write", csr_write, 0);
        chk("abort_no_rsp", {core_rsp_valid, dbg_rsp_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_next_no_rsp", {core_rsp_valid, dbg_rsp_valid}, 0);
        chk("abort_next_no_write", csr_write, 0);
        do_access(mk(0, 0, 12'h341, 3'b010, 32'h0, 32'h0, 5'd0, 32'h8000_0000, 0), w);
        chk("abort_ready_first_idle", w, 0);

`ifdef CSR_ARB_DEBUG_EN
        // Debug accesses
        vecs.delete();
        vecs.push_back(mk(1, 1, 12'h341, 3'b000, 32'h8000_0004, 32'h0, 5'd0, 32'h8000_0000, 0));
        vecs.push_back(mk(1, 0, 12'h341, 3'b000, 32'h0,         32'h0, 5'd0, 32'h8000_0004, 0));
        vecs.push_back(mk(1, 0, 12'h7B0, 3'b000, 32'h0,         32'h0, 5'd0, 32'h4000_0003, 0));
        vecs.push_back(mk(1, 1, 12'h7B0, 3'b000, 32'h4000_0007, 32'h0, 5'd0, 32'h4000_0003, 0));
        vecs.push_back(mk(0, 0, 12'h7B0, 3'b010, 32'h0,         32'h0, 5'd0, 32'h4000_0007, 1));
        foreach (vecs[k]) do_access(vecs[k], w);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
